// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM state codes and small op-decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic isSignedOp(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Pure combinational; the caller owns the acc/reg state.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] rg,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] accNext,
  output logic [WIDTH-1:0] rgNext
);

  logic [WIDTH:0] addSum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign addSum  = {1'b0, acc} + (rg[0] ? {1'b0, operand} : '0);
  assign shifted = {acc, rg[WIDTH-1]};
  // remainder stays below the divisor, so diff[WIDTH] is a clean borrow
  assign diff    = shifted - {1'b0, operand};

  always_comb begin
    accNext = addSum[WIDTH:1];
    rgNext  = {addSum[0], rg[WIDTH-1:1]};
    if (isDiv) begin
      if (diff[WIDTH]) begin
        accNext = shifted[WIDTH-1:0];
        rgNext  = {rg[WIDTH-2:0], 1'b0};
      end else begin
        accNext = diff[WIDTH-1:0];
        rgNext  = {rg[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned MULT/DIV unit driving the HI/LO registers.
// Magnitudes are iterated; signs are re-applied in the FIX state.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               isDiv;
  logic               negRes;
  logic               negRem;
  logic               dzPend;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   rg;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   accNext;
  logic [WIDTH-1:0]   rgNext;
  logic               sgn;
  logic               reqDiv;
  logic               reqDz;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  assign sgn    = isSignedOp(op);
  assign reqDiv = isDivOp(op);
  assign reqDz  = reqDiv && (b == '0);
  // MIN negates to itself, which is still the right unsigned magnitude
  assign magA   = (sgn && a[WIDTH-1]) ? -a : a;
  assign magB   = (sgn && b[WIDTH-1]) ? -b : b;

  assign busy    = (state != S_IDLE);
  assign prod    = {acc, rg};
  assign prodFix = negRes ? -prod : prod;
  assign quoFix  = negRes ? -rg : rg;
  assign remFix  = negRem ? -acc : acc;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .isDiv  (isDiv),
    .acc    (acc),
    .rg     (rg),
    .operand(operand),
    .accNext(accNext),
    .rgNext (rgNext)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      acc      <= '0;
      rg       <= '0;
      operand  <= '0;
      isDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      dzPend   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            isDiv    <= reqDiv;
            negRes   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            negRem   <= sgn & a[WIDTH-1];
            dzPend   <= reqDz;
            acc      <= '0;
            cnt      <= CNT_INIT;
            if (reqDiv) begin
              rg      <= magA;
              operand <= magB;
            end else begin
              rg      <= magB;
              operand <= magA;
            end
            state <= reqDz ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          acc <= accNext;
          rg  <= rgNext;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          done  <= 1'b1;
          cnt   <= '0;
          state <= S_IDLE;
          if (dzPend) begin
            div_zero <= 1'b1;
          end else if (isDiv) begin
            hi <= remFix;
            lo <= quoFix;
          end else begin
            {hi, lo} <= prodFix;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
